// File: rtl/fixed_relu_backward.sv
// rtl/fixed_relu_backward.sv - ReLU gradient gate driven by a FIFO of forward "was positive" masks
// Forward beats push a per-element mask; each backward beat pops one and zeroes non-positive lanes.
module fixed_relu_backward #(
  parameter int IN_0_WIDTH = 8,
  parameter int IN_0_SIZE  = 8,
  parameter int GRAD_WIDTH = 8,
  parameter int MASK_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_0_WIDTH-1:0]         data_in_0 [IN_0_SIZE],
  input  logic                          data_in_0_valid,
  output logic                          data_in_0_ready,
  input  logic [GRAD_WIDTH-1:0]         grad_out_0 [IN_0_SIZE],
  input  logic                          grad_out_0_valid,
  output logic                          grad_out_0_ready,
  output logic [GRAD_WIDTH-1:0]         grad_in_0 [IN_0_SIZE],
  output logic                          grad_in_0_valid,
  input  logic                          grad_in_0_ready,
  output logic [$clog2(MASK_DEPTH):0]   mask_count
);

  localparam int PTR_W = $clog2(MASK_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(MASK_DEPTH);

  logic [IN_0_SIZE-1:0]  mask_mem_q [MASK_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [GRAD_WIDTH-1:0] grad_q [IN_0_SIZE];
  logic [GRAD_WIDTH-1:0] grad_d [IN_0_SIZE];
  logic                  valid_q, valid_d;

  logic [IN_0_SIZE-1:0]  mask_wr;
  logic [IN_0_SIZE-1:0]  mask_rd;
  logic                  push, pop;

  // Strictly positive: sign bit clear and not zero, so 0 gates its gradient like the forward ReLU.
  always_comb begin
    mask_wr = '0;
    for (int i = 0; i < IN_0_SIZE; i++) begin
      mask_wr[i] = !data_in_0[i][IN_0_WIDTH-1] && (data_in_0[i] != '0);
    end
  end

  assign data_in_0_ready  = (count_q != FULL_COUNT);
  assign grad_out_0_ready = (count_q != '0) && (!valid_q || grad_in_0_ready);
  assign push             = data_in_0_valid && data_in_0_ready;
  assign pop              = grad_out_0_valid && grad_out_0_ready;
  assign mask_rd          = mask_mem_q[rd_ptr_q];

  assign grad_in_0        = grad_q;
  assign grad_in_0_valid  = valid_q;
  assign mask_count       = count_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    grad_d  = grad_q;
    valid_d = valid_q;
    if (pop) begin
      for (int i = 0; i < IN_0_SIZE; i++) begin
        grad_d[i] = mask_rd[i] ? grad_out_0[i] : '0;
      end
      valid_d = 1'b1;
    end else if (grad_in_0_ready) begin
      valid_d = 1'b0;
    end
  end

  // Mask storage needs no reset: entries are only read after the count says they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      mask_mem_q[wr_ptr_q] <= mask_wr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      grad_q   <= '{default: '0};
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      grad_q   <= grad_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_fixed_relu_backward.sv
// tb/tb_fixed_relu_backward.sv - directed self-checking bench for fixed_relu_backward
// Four lanes of 8 bits; lane 0 is the low byte of every packed 32-bit word used below.
module tb_fixed_relu_backward;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] data_in_0 [N];
  logic         data_in_0_valid = 1'b0;
  logic         data_in_0_ready;
  logic [W-1:0] grad_out_0 [N];
  logic         grad_out_0_valid = 1'b0;
  logic         grad_out_0_ready;
  logic [W-1:0] grad_in_0 [N];
  logic         grad_in_0_valid;
  logic         grad_in_0_ready = 1'b0;
  logic [4:0]   mask_count;

  int n_checks = 0;
  int n_fail   = 0;

  fixed_relu_backward #(
    .IN_0_WIDTH(W), .IN_0_SIZE(N), .GRAD_WIDTH(W), .MASK_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in_0(data_in_0), .data_in_0_valid(data_in_0_valid), .data_in_0_ready(data_in_0_ready),
    .grad_out_0(grad_out_0), .grad_out_0_valid(grad_out_0_valid), .grad_out_0_ready(grad_out_0_ready),
    .grad_in_0(grad_in_0), .grad_in_0_valid(grad_in_0_valid), .grad_in_0_ready(grad_in_0_ready),
    .mask_count(mask_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] out_word();
    return {grad_in_0[3], grad_in_0[2], grad_in_0[1], grad_in_0[0]};
  endfunction

  // Forward data realising a mask pattern: positive where set, alternately 0 and -128 where clear.
  function automatic logic [31:0] fwd_word(input logic [3:0] pat);
    logic [31:0] w;
    for (int j = 0; j < N; j++) begin
      w[8*j +: 8] = pat[j] ? 8'(j + 1) : ((j % 2) != 0 ? 8'h80 : 8'h00);
    end
    return w;
  endfunction

  function automatic logic [31:0] expand(input logic [3:0] pat);
    logic [31:0] w;
    for (int j = 0; j < N; j++) w[8*j +: 8] = pat[j] ? 8'hFF : 8'h00;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input logic [31:0] w);
    for (int j = 0; j < N; j++) data_in_0[j] = w[8*j +: 8];
  endtask

  task automatic set_grad(input logic [31:0] w);
    for (int j = 0; j < N; j++) grad_out_0[j] = w[8*j +: 8];
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_fwd('0);
    set_grad('0);
    tick();
    tick();
    n_checks++; if (grad_in_0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", grad_in_0_valid); end
    n_checks++; if (mask_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", mask_count); end
    n_checks++; if (data_in_0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fwd_ready: got %b want 1", data_in_0_ready); end
    n_checks++; if (grad_out_0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_grad_ready: got %b want 0", grad_out_0_ready); end
    n_checks++; if (out_word() !== 32'h0) begin n_fail++; $display("FAIL reset_grad_out: got %h want 0", out_word()); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_mask();
    set_fwd({8'd127, 8'd0, 8'hFD, 8'd5});
    data_in_0_valid = 1'b1;
    tick();
    data_in_0_valid = 1'b0;
    n_checks++; if (mask_count !== 5'd1) begin n_fail++; $display("FAIL basic_count_push: got %0d want 1", mask_count); end
    set_grad({8'd40, 8'd30, 8'd20, 8'd10});
    grad_out_0_valid = 1'b1;
    grad_in_0_ready  = 1'b1;
    #1;
    n_checks++; if (grad_out_0_ready !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %b want 1", grad_out_0_ready); end
    tick();
    grad_out_0_valid = 1'b0;
    n_checks++; if (out_word() !== {8'd40, 8'd0, 8'd0, 8'd10}) begin n_fail++; $display("FAIL basic_grad: got %h want %h", out_word(), {8'd40, 8'd0, 8'd0, 8'd10}); end
    n_checks++; if (grad_in_0_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", grad_in_0_valid); end
    n_checks++; if (mask_count !== 5'd0) begin n_fail++; $display("FAIL basic_count_pop: got %0d want 0", mask_count); end
    tick();
    n_checks++; if (grad_in_0_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", grad_in_0_valid); end
  endtask

  task automatic test_fill_wrap();
    logic [3:0] pat;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < D; i++) begin
        pat = 4'(i) ^ (r != 0 ? 4'hA : 4'h0);
        set_fwd(fwd_word(pat));
        data_in_0_valid = 1'b1;
        tick();
      end
      n_checks++; if (mask_count !== 5'd16) begin n_fail++; $display("FAIL fill_count r%0d: got %0d want 16", r, mask_count); end
      set_fwd(fwd_word(4'hF));
      #1;
      n_checks++; if (data_in_0_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready r%0d: got %b want 0", r, data_in_0_ready); end
      tick();
      data_in_0_valid = 1'b0;
      n_checks++; if (mask_count !== 5'd16) begin n_fail++; $display("FAIL full_refused r%0d: got %0d want 16", r, mask_count); end
      set_grad(32'hFFFF_FFFF);
      grad_out_0_valid = 1'b1;
      grad_in_0_ready  = 1'b1;
      for (int i = 0; i < D; i++) begin
        tick();
        pat = 4'(i) ^ (r != 0 ? 4'hA : 4'h0);
        n_checks++; if (out_word() !== expand(pat)) begin n_fail++; $display("FAIL drain_data r%0d b%0d: got %h want %h", r, i, out_word(), expand(pat)); end
        n_checks++; if (mask_count !== 5'(15 - i)) begin n_fail++; $display("FAIL drain_count r%0d b%0d: got %0d want %0d", r, i, mask_count, 15 - i); end
      end
      grad_out_0_valid = 1'b0;
      n_checks++; if (grad_out_0_ready !== 1'b0) begin n_fail++; $display("FAIL empty_ready r%0d: got %b want 0", r, grad_out_0_ready); end
      tick();
    end
  endtask

  task automatic test_empty_stall();
    grad_in_0_ready = 1'b1;
    set_grad({8'd4, 8'd3, 8'd2, 8'd1});
    grad_out_0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (grad_out_0_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready c%0d: got %b want 0", i, grad_out_0_ready); end
      tick();
    end
    set_fwd({8'd1, 8'd1, 8'd1, 8'd1});
    data_in_0_valid = 1'b1;
    #1;
    n_checks++; if (grad_out_0_ready !== 1'b0) begin n_fail++; $display("FAIL stall_push_cycle: got %b want 0", grad_out_0_ready); end
    tick();
    data_in_0_valid = 1'b0;
    #1;
    n_checks++; if (grad_out_0_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b want 1", grad_out_0_ready); end
    tick();
    grad_out_0_valid = 1'b0;
    n_checks++; if (out_word() !== {8'd4, 8'd3, 8'd2, 8'd1}) begin n_fail++; $display("FAIL stall_data: got %h want 04030201", out_word()); end
    n_checks++; if (mask_count !== 5'd0) begin n_fail++; $display("FAIL stall_count: got %0d want 0", mask_count); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] g;
    g = 32'h1234_5678;
    grad_in_0_ready = 1'b0;
    set_fwd(fwd_word(4'b0101)); data_in_0_valid = 1'b1; tick();
    set_fwd(fwd_word(4'b1110)); tick();
    set_fwd(fwd_word(4'b0011)); tick();
    data_in_0_valid = 1'b0;
    n_checks++; if (mask_count !== 5'd3) begin n_fail++; $display("FAIL bp_count3: got %0d want 3", mask_count); end
    set_grad(g);
    grad_out_0_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (grad_out_0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready c%0d: got %b want 0", i, grad_out_0_ready); end
      n_checks++; if (out_word() !== (g & expand(4'b0101))) begin n_fail++; $display("FAIL bp_hold c%0d: got %h want %h", i, out_word(), g & expand(4'b0101)); end
      n_checks++; if (grad_in_0_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d: got %b want 1", i, grad_in_0_valid); end
      n_checks++; if (mask_count !== 5'd2) begin n_fail++; $display("FAIL bp_count c%0d: got %0d want 2", i, mask_count); end
      tick();
    end
    grad_in_0_ready = 1'b1;
    #1;
    n_checks++; if (grad_out_0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", grad_out_0_ready); end
    tick();
    n_checks++; if (out_word() !== (g & expand(4'b1110))) begin n_fail++; $display("FAIL bp_beat2: got %h want %h", out_word(), g & expand(4'b1110)); end
    tick();
    grad_out_0_valid = 1'b0;
    n_checks++; if (out_word() !== (g & expand(4'b0011))) begin n_fail++; $display("FAIL bp_beat3: got %h want %h", out_word(), g & expand(4'b0011)); end
    n_checks++; if (mask_count !== 5'd0) begin n_fail++; $display("FAIL bp_count_end: got %0d want 0", mask_count); end
    tick();
    n_checks++; if (grad_in_0_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", grad_in_0_valid); end
  endtask

  task automatic test_simultaneous();
    grad_in_0_ready = 1'b1;
    data_in_0_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      set_fwd(fwd_word(4'(k)));
      tick();
    end
    n_checks++; if (mask_count !== 5'd5) begin n_fail++; $display("FAIL sim_count5: got %0d want 5", mask_count); end
    set_fwd(fwd_word(4'hF));
    set_grad(32'hFFFF_FFFF);
    grad_out_0_valid = 1'b1;
    tick();
    grad_out_0_valid = 1'b0;
    n_checks++; if (mask_count !== 5'd5) begin n_fail++; $display("FAIL sim_pushpop5: got %0d want 5", mask_count); end
    n_checks++; if (out_word() !== expand(4'd1)) begin n_fail++; $display("FAIL sim_data5: got %h want %h", out_word(), expand(4'd1)); end
    repeat (11) tick();
    n_checks++; if (mask_count !== 5'd16) begin n_fail++; $display("FAIL sim_count16: got %0d want 16", mask_count); end
    grad_out_0_valid = 1'b1;
    #1;
    n_checks++; if (data_in_0_ready !== 1'b0) begin n_fail++; $display("FAIL sim_full_fwd_ready: got %b want 0", data_in_0_ready); end
    n_checks++; if (grad_out_0_ready !== 1'b1) begin n_fail++; $display("FAIL sim_full_grad_ready: got %b want 1", grad_out_0_ready); end
    tick();
    data_in_0_valid  = 1'b0;
    grad_out_0_valid = 1'b0;
    n_checks++; if (mask_count !== 5'd15) begin n_fail++; $display("FAIL sim_count15: got %0d want 15", mask_count); end
    n_checks++; if (out_word() !== expand(4'd2)) begin n_fail++; $display("FAIL sim_data16: got %h want %h", out_word(), expand(4'd2)); end
  endtask

  task automatic test_async_reset();
    grad_in_0_ready  = 1'b0;
    grad_out_0_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (grad_in_0_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", grad_in_0_valid); end
    n_checks++; if (mask_count !== 5'd0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", mask_count); end
    n_checks++; if (data_in_0_ready !== 1'b1) begin n_fail++; $display("FAIL areset_fwd_ready: got %b want 1", data_in_0_ready); end
    grad_in_0_ready = 1'b1;
    #1;
    n_checks++; if (grad_out_0_ready !== 1'b0) begin n_fail++; $display("FAIL areset_grad_ready: got %b want 0", grad_out_0_ready); end
    n_checks++; if (out_word() !== 32'h0) begin n_fail++; $display("FAIL areset_grad_out: got %h want 0", out_word()); end
    grad_out_0_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_mask();
    test_fill_wrap();
    test_empty_stall();
    test_backpressure();
    test_simultaneous();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_relu_backward.md
# fixed_relu_backward

Gradient-path companion to the fixed-point ReLU activation: during the forward pass it taps the ReLU input stream and stores a per-element "was positive" mask in a FIFO. During the backward pass it consumes the upstream gradient stream in the same beat order and emits the gradient with every element zeroed wherever the forward input was ≤ 0. It sits beside the forward ReLU in the training datapath, between the downstream layer's gradient output and the upstream layer's gradient input.

## Interface
- IN_0_WIDTH, 8, bit width of each forward activation element (signed two's complement)
- IN_0_SIZE, 8, elements per beat on all three streams
- GRAD_WIDTH, 8, bit width of each gradient element
- MASK_DEPTH, 16, number of forward beats the mask FIFO holds (power of two, ≥2)

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- data_in_0  input  IN_0_WIDTH × [IN_0_SIZE]  forward activation tap
- data_in_0_valid  input  1  forward beat valid
- data_in_0_ready  output  1  mask FIFO can accept a forward beat
- grad_out_0  input  GRAD_WIDTH × [IN_0_SIZE]  incoming gradient (dL/d ReLU output)
- grad_out_0_valid  input  1  incoming gradient valid
- grad_out_0_ready  output  1  block accepts incoming gradient
- grad_in_0  output  GRAD_WIDTH × [IN_0_SIZE]  outgoing gradient (dL/d ReLU input), registered
- grad_in_0_valid  output  1  outgoing gradient valid
- grad_in_0_ready  input  1  downstream accepts outgoing gradient
- mask_count  output  $clog2(MASK_DEPTH)+1  number of stored masks

## Operation
- Mask bit i = 1 iff $signed(data_in_0[i]) > 0. A value of exactly zero gives mask 0, matching the forward ReLU, which maps 0 to 0.
- Forward push: on data_in_0_valid && data_in_0_ready, write the IN_0_SIZE-bit mask at the write pointer. Advance the write pointer mod MASK_DEPTH.
- data_in_0_ready = (mask_count != MASK_DEPTH). It does not depend on a same-cycle pop.
- Backward accept: grad_out_0_ready = (mask_count != 0) && (!grad_in_0_valid || grad_in_0_ready).
- On grad_out_0_valid && grad_out_0_ready:
  - For each i, the grad_in_0[i] register loads grad_out_0[i] if mask bit i = 1, else 0.
  - grad_in_0_valid is set to 1.
  - The read pointer advances mod MASK_DEPTH (pop).
- Output hold: when grad_in_0_valid && !grad_in_0_ready, grad_in_0 and grad_in_0_valid hold stable and no pop occurs.
- Output drain: when grad_in_0_valid && grad_in_0_ready and there is no new accept, grad_in_0_valid clears.
- mask_count:
  - +1 on a push only.
  - −1 on a pop only.
  - Unchanged on a simultaneous push and pop.
- No arithmetic on gradient values: pure select-or-zero, width preserved.
- Forward activations are not forwarded; this block is a tap only. The forward ReLU drives the activation path.

## Timing
- Reset (rst = 0, asynchronous):
  - grad_in_0_valid = 0, grad_in_0 = all zeros, mask_count = 0.
  - Both pointers = 0.
  - Therefore data_in_0_ready = 1 and grad_out_0_ready = 0.
- Reset mid-operation discards all stored masks and any held output beat immediately, without waiting for a clock edge.
- Latency:
  - A push at edge t makes the mask poppable from cycle t+1. There is no bypass for a push and a gradient arriving in the same cycle.
  - An accepted gradient appears on grad_in_0 one cycle later.
- Throughput: one gradient beat per cycle while masks are available and downstream is ready.
- Full (mask_count = MASK_DEPTH): data_in_0_ready = 0 even if a pop occurs in the same cycle. A push is retried next cycle.
- Empty (mask_count = 0): grad_out_0_ready = 0. An incoming gradient waits and is never paired with a stale mask.
- Pointers wrap from MASK_DEPTH−1 to 0 with no gap.
- Valid/ready rules:
  - A producer must hold data and valid stable until a transfer occurs.
  - This block never drops grad_in_0_valid without a transfer.

## Test plan
- Reset then idle:
  - Stimulus: assert rst = 0 mid-stream.
  - Required: grad_in_0_valid = 0, mask_count = 0, data_in_0_ready = 1, grad_out_0_ready = 0, all asynchronously.
- Basic mask (IN_0_SIZE = 4, widths 8):
  - Stimulus: push forward {5, −3, 0, 127}, then gradient {10, 20, 30, 40}.
  - Required: grad_in_0 = {10, 0, 0, 40} one cycle after accept; mask_count returns to 0.
- Fill, full and wrap:
  - Stimulus: push 16 beats with distinct patterns.
  - Required: data_in_0_ready = 0 at count 16.
  - Then: pop 16 gradients of all 0xFF.
  - Required: outputs reproduce the masks in push order.
  - Then: repeat once more to exercise pointer wrap.
- Empty stall:
  - Stimulus: assert grad_out_0_valid with mask_count = 0 for 5 cycles, then push one forward beat.
  - Required: grad_out_0_ready = 0 during the stall and in the push cycle; the gradient is accepted in the next cycle.
- Backpressure:
  - Stimulus: 3 masks stored, grad_in_0_ready = 0 for 4 cycles.
  - Required: the first output holds stable and grad_out_0_ready = 0; no further pops occur, mask_count stays at 2.
  - Then: release backpressure.
  - Required: one output per cycle thereafter.
- Simultaneous push/pop at count 5:
  - Stimulus: push and pop in the same cycle.
  - Required: count stays 5.
  - Stimulus: at count 16, push plus pop in the same cycle.
  - Required: the push is refused, the pop completes, and the count becomes 15.
